// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit for the EXE stage: shift-add multiply,
// restoring divide, one step per cycle, with a HI/LO result pair and pipeline stall.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_a, neg_b, dz;

  // Operand decode at start: magnitudes and sign flags (signed ops only).
  logic             in_div, in_neg_a, in_neg_b;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    in_div   = op[1];
    in_neg_a = ~op[0] & rs_data[WIDTH-1];
    in_neg_b = ~op[0] & rt_data[WIDTH-1];
    a_abs    = in_neg_a ? -rs_data : rs_data;
    b_abs    = in_neg_b ? -rt_data : rt_data;
  end

  // One iteration. Multiply: acc = {partial, multiplier}, opnd = multiplicand.
  // Divide: acc = {remainder, dividend/quotient}, opnd = divisor.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step;

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (!is_div)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction. With a zero divisor every trial subtract succeeds, so the
  // remainder ends as |rs| and its sign fix restores the original rs_data for hi.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix, quo, rem;

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quo      = acc[WIDTH-1:0];
    rem      = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      hi_fix = neg_a ? -rem : rem;
      lo_fix = dz ? {WIDTH{1'b1}} : ((neg_a ^ neg_b) ? -quo : quo);
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: all state, including the datapath registers, is reset; there is no
  // memory array here whose reset would be costly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          state  <= CALC;
          cnt    <= CNT_W'(WIDTH);
          is_div <= in_div;
          neg_a  <= in_neg_a;
          neg_b  <= in_neg_b;
          dz     <= in_div && (rt_data == '0);
          acc    <= {{WIDTH{1'b0}}, (in_div ? a_abs : b_abs)};
          opnd   <= in_div ? b_abs : a_abs;
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
          if (flush)                     state <= IDLE;
          else if (cnt == CNT_W'(1))     state <= FIX;
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            hi    <= hi_fix;
            lo    <= lo_fix;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only; start never reaches busy combinationally.
  assign busy        = (state == CALC) || (state == FIX);
  assign done        = (state == DONE);
  assign hilo_we     = done;
  assign div_by_zero = done & dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, flush, ignored
// start, asynchronous reset and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  rs_data = '0;
  logic [W-1:0]  rt_data = '0;
  logic          flush = 1'b0;
  logic          busy, done, hilo_we, div_by_zero;
  logic [W-1:0]  hi, lo;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .busy(busy), .done(done), .hilo_we(hilo_we),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero,
  // which gives the quotient/remainder sign rules directly.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    z  = 1'b0;
    case (o)
      2'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      default: begin
        if (b == '0) begin
          z = 1'b1; l = '1; h = a;
        end else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0];
        end else begin
          up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0];
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eh, el;
    logic ez;
    int n, busy_n;
    model(o, a, b, eh, el, ez);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    n = 1; busy_n = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd34);
    check({tag, " busy_cycles"}, 64'(busy_n), 64'd33);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, el});
    check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, ez});
    check({tag, " hilo_we"}, {63'd0, hilo_we}, 64'd1);
    last_hi = eh; last_lo = el;
    @(negedge clk);
    check({tag, " done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int n, dones;
    logic [W-1:0] eh, el, ghi, glo, a, b;
    logic ez;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", {58'd0, busy, done, hilo_we, div_by_zero, |hi, |lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", {63'd0, busy}, 64'd0);

    // Directed cases
    run_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0003, "mult_neg2x3");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
    run_op(2'd3, 32'd100, 32'd7, "divu_100_7");
    run_op(2'd3, 32'h0000_1234, 32'd0, "divu_by_zero");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd0, "div_neg_by_zero");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

    // Flush at cycle 10: no done, hi/lo keep previous result
    @(negedge clk);
    start = 1'b1; op = 2'd0; rs_data = 32'd12345; rt_data = 32'd678;
    @(negedge clk);
    start = 1'b0; n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    check("flush pre busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy_drop", {63'd0, busy}, 64'd0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    check("flush no_done", 64'(dones), 64'd0);
    check("flush hi_kept", {32'd0, hi}, {32'd0, last_hi});
    check("flush lo_kept", {32'd0, lo}, {32'd0, last_lo});

    // Start while busy is ignored
    model(2'd1, 32'd1000, 32'd3000, eh, el, ez);
    @(negedge clk);
    start = 1'b1; op = 2'd1; rs_data = 32'd1000; rt_data = 32'd3000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd3; rs_data = 32'd77; rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    dones = 0; ghi = '0; glo = '0;
    repeat (80) begin
      @(negedge clk);
      if (done) begin
        if (dones == 0) begin ghi = hi; glo = lo; end
        dones++;
      end
    end
    check("busy_start done_count", 64'(dones), 64'd1);
    check("busy_start hi", {32'd0, ghi}, {32'd0, eh});
    check("busy_start lo", {32'd0, glo}, {32'd0, el});

    // Asynchronous reset mid-CALC with nonzero hi/lo held beforehand
    run_op(2'd1, 32'h0001_0000, 32'h0003_0005, "multu_pre_reset");
    @(negedge clk);
    start = 1'b1; op = 2'd0; rs_data = 32'd99; rt_data = 32'd101;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset outputs", {58'd0, busy, done, hilo_we, div_by_zero, |hi, |lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'd1, 32'd3, 32'd5, "multu_3x5");

    // Randomized operations with corner-biased operands
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000;
        1: a = 32'(-$urandom_range(1, 100));
        2: a = $urandom_range(0, 1000);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = '1;
        2: b = $urandom_range(1, 50);
        3: b = 32'(-$urandom_range(1, 50));
        default: b = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), a, b, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
